// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the front end of the five-stage core.
//   XLEN            : datapath width
//   CORE_RESET_PC   : default first fetch address after reset
//   CORE_NOP_INSTR  : addi x0,x0,0, presented when no instruction is held
//   fetch_state_e   : fetch FSM states
//   word_align      : clears the two low address bits
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] CORE_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] CORE_NOP_INSTR = 32'h0000_0013;

    // IDLE : nothing outstanding
    // WAIT : one request outstanding, its data is wanted
    // DRAIN: one request outstanding, its data will be thrown away
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding register that catches a
// fetched word when the decode-facing output register is stalled.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture load_pc/load_instr, mark valid
//   unload            : entry consumed, mark empty
//   flush             : discard entry (wins over load and unload)
//   load_pc/load_instr: entry to capture
//   skid_pc/skid_instr: held entry
//   skid_valid        : entry present
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] skid_pc,
    output logic [XLEN-1:0] skid_instr,
    output logic            skid_valid
);

    // Entry register: flush beats load beats unload.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_pc    <= CORE_RESET_PC;
            skid_instr <= CORE_NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (load) begin
            skid_pc    <= load_pc;
            skid_instr <= load_instr;
            skid_valid <= 1'b1;
        end else if (unload) begin
            skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, keeps at most one word
// read in flight to the instruction ROM, and hands {pc, instr} to decode
// through an output register backed by a one-entry skid buffer.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   stall                         : decode cannot accept, hold outputs
//   redirect_valid/redirect_sel   : control transfer (0: branch/JAL, 1: JALR)
//   pc_add_imm_32                 : branch/JAL target
//   rs1_data_add_imm_32_for_pc    : JALR target before bit-0 masking
//   rom_req/rom_addr              : registered read request, word aligned
//   rom_ready/rom_data            : one-cycle response for the request
//   pc/instr/pc_from_rom_ready    : IF/ID register and its valid
//   pc_misaligned                 : one-cycle pulse, redirect target unaligned
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = CORE_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = CORE_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_sel,
    input  logic [XLEN-1:0] pc_add_imm_32,
    input  logic [XLEN-1:0] rs1_data_add_imm_32_for_pc,
    output logic            rom_req,
    output logic [XLEN-1:0] rom_addr,
    input  logic            rom_ready,
    input  logic [XLEN-1:0] rom_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            pc_from_rom_ready,
    output logic            pc_misaligned
);

    fetch_state_e    state_r, state_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_s;
    logic [XLEN-1:0] jalr_target_s, target_s;
    logic            issue_s, accept_s, space_s, misaligned_s;
    logic            out_load_rom_s, out_load_skid_s, out_clear_s;
    logic            skid_load_s, skid_unload_s, skid_flush_s;
    logic [XLEN-1:0] skid_pc_s, skid_instr_s;
    logic            skid_valid_s;

    // JALR clears bit 0 of its sum; the remaining low bit is what flags misalignment.
    assign jalr_target_s = rs1_data_add_imm_32_for_pc & 32'hFFFF_FFFE;
    assign target_s      = redirect_sel ? jalr_target_s : pc_add_imm_32;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load_s),
        .unload     (skid_unload_s),
        .flush      (skid_flush_s),
        .load_pc    (fetch_pc_r),
        .load_instr (rom_data),
        .skid_pc    (skid_pc_s),
        .skid_instr (skid_instr_s),
        .skid_valid (skid_valid_s)
    );

    // Next-PC mux, storage steering and FSM next state.
    always_comb begin
        state_s         = state_r;
        fetch_pc_s      = fetch_pc_r;
        issue_s         = 1'b0;
        accept_s        = 1'b0;
        space_s         = 1'b1;
        misaligned_s    = 1'b0;
        out_load_rom_s  = 1'b0;
        out_load_skid_s = 1'b0;
        out_clear_s     = 1'b0;
        skid_load_s     = 1'b0;
        skid_unload_s   = 1'b0;
        skid_flush_s    = 1'b0;
        if (redirect_valid) begin
            // Redirect flushes everything; any data returning now is dropped.
            fetch_pc_s   = word_align(target_s);
            misaligned_s = |target_s[1:0];
            out_clear_s  = 1'b1;
            skid_flush_s = 1'b1;
            case (state_r)
                IDLE: begin
                    state_s = WAIT;
                    issue_s = 1'b1;
                end
                WAIT, DRAIN: begin
                    if (rom_ready) begin
                        state_s = WAIT;
                        issue_s = 1'b1;
                    end else begin
                        // Old request still in flight: keep it, discard its data.
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            accept_s = (state_r == WAIT) && rom_ready;
            if (accept_s) begin
                fetch_pc_s = fetch_pc_r + 32'd4;
                if (!pc_from_rom_ready || !stall) begin
                    out_load_rom_s = 1'b1;
                end else begin
                    skid_load_s = 1'b1;
                end
            end else if (!stall) begin
                if (skid_valid_s) begin
                    out_load_skid_s = 1'b1;
                    skid_unload_s   = 1'b1;
                end else begin
                    out_clear_s = 1'b1;
                end
            end else begin
                out_clear_s = 1'b0;
            end
            // A request may run across this edge only if the skid ends up empty.
            space_s = !(skid_load_s || (skid_valid_s && !skid_unload_s));
            case (state_r)
                IDLE: begin
                    if (space_s) begin
                        state_s = WAIT;
                        issue_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT, DRAIN: begin
                    if (rom_ready) begin
                        if (space_s) begin
                            state_s = WAIT;
                            issue_s = 1'b1;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // FSM, fetch PC and ROM request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            fetch_pc_r    <= RESET_PC;
            rom_req       <= 1'b0;
            rom_addr      <= RESET_PC;
            pc_misaligned <= 1'b0;
        end else begin
            state_r       <= state_s;
            fetch_pc_r    <= fetch_pc_s;
            rom_req       <= (state_s != IDLE);
            pc_misaligned <= misaligned_s;
            if (issue_s) begin
                rom_addr <= word_align(fetch_pc_s);
            end
        end
    end

    // IF/ID output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= RESET_PC;
            instr             <= NOP_INSTR;
            pc_from_rom_ready <= 1'b0;
        end else if (out_load_rom_s) begin
            pc                <= fetch_pc_r;
            instr             <= rom_data;
            pc_from_rom_ready <= 1'b1;
        end else if (out_load_skid_s) begin
            pc                <= skid_pc_s;
            instr             <= skid_instr_s;
            pc_from_rom_ready <= 1'b1;
        end else if (out_clear_s) begin
            instr             <= NOP_INSTR;
            pc_from_rom_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A ROM model answers
// requests; every word the bench expects decode to see is queued as
// {pc, instr} when answered and popped when decode consumes the output.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, redirect_sel;
    logic [31:0] pc_add_imm_32, rs1_data_add_imm_32_for_pc;
    logic        rom_req, rom_ready, pc_from_rom_ready, pc_misaligned;
    logic [31:0] rom_addr, rom_data, pc, instr;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc, data_base;
    logic        draining, exp_mis, rom_hold, rom_kick;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk                        (clk),
        .rst                        (rst),
        .stall                      (stall),
        .redirect_valid             (redirect_valid),
        .redirect_sel               (redirect_sel),
        .pc_add_imm_32              (pc_add_imm_32),
        .rs1_data_add_imm_32_for_pc (rs1_data_add_imm_32_for_pc),
        .rom_req                    (rom_req),
        .rom_addr                   (rom_addr),
        .rom_ready                  (rom_ready),
        .rom_data                   (rom_data),
        .pc                         (pc),
        .instr                      (instr),
        .pc_from_rom_ready          (pc_from_rom_ready),
        .pc_misaligned              (pc_misaligned)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return data_base + (a >> 2);
    endfunction

    // One clock: called at a negedge with this cycle's inputs set, returns at the next negedge.
    task automatic tick();
        logic [31:0] tgt;
        logic [63:0] e;
        check_eq("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, exp_mis});
        tgt       = redirect_sel ? (rs1_data_add_imm_32_for_pc & 32'hFFFF_FFFE) : pc_add_imm_32;
        rom_ready = 1'b0;
        rom_data  = 32'h0;
        if (rom_kick) begin
            rom_ready = 1'b1;
            rom_data  = 32'hDEAD_BEEF;
        end else if (!rst && rom_req && !rom_hold) begin
            rom_ready = 1'b1;
            rom_data  = rom_word(rom_addr);
        end
        if (rst) begin
            sb_q.delete();
            exp_pc   = 32'h0;
            draining = 1'b0;
            exp_mis  = 1'b0;
        end else begin
            if (pc_from_rom_ready && !stall && !redirect_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_extra_out", {31'd0, pc_from_rom_ready}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("out_pc", pc, e[63:32]);
                    check_eq("out_instr", instr, e[31:0]);
                end
            end
            if (redirect_valid) begin
                sb_q.delete();
                exp_pc   = tgt & 32'hFFFF_FFFC;
                exp_mis  = |tgt[1:0];
                draining = rom_ready ? 1'b0 : (draining | rom_req);
            end else begin
                exp_mis = 1'b0;
                if (rom_ready && !rom_kick) begin
                    if (draining) begin
                        draining = 1'b0;
                    end else begin
                        check_eq("rom_addr", rom_addr, exp_pc);
                        sb_q.push_back({exp_pc, rom_word(exp_pc)});
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        rom_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0;
        pc_add_imm_32 = 32'h0; rs1_data_add_imm_32_for_pc = 32'h0;
        rom_ready = 1'b0; rom_data = 32'h0; rom_hold = 1'b1; rom_kick = 1'b0;
        data_base = 32'h0; exp_pc = 32'h0; draining = 1'b0; exp_mis = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset values, then first request one edge after release.
        tick();
        check_eq("rst_rom_req", {31'd0, rom_req}, 32'd0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_valid", {31'd0, pc_from_rom_ready}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("first_req", {31'd0, rom_req}, 32'd1);
        check_eq("first_addr", rom_addr, 32'h0);

        // Streaming at one word per cycle.
        data_base = 32'hA0;
        rom_hold  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stream_valid", {31'd0, pc_from_rom_ready}, 32'd1);
        end
        rom_hold = 1'b1;
        tick();
        check_eq("stream_end_valid", {31'd0, pc_from_rom_ready}, 32'd0);
        check_eq("stream_next_addr", rom_addr, 32'h10);
        check_eq("stream_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset with a request outstanding; responses around release are ignored.
        rst = 1'b1;
        tick();
        rom_kick = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rom_kick = 1'b0;
        check_eq("rstw_req", {31'd0, rom_req}, 32'd1);
        check_eq("rstw_addr", rom_addr, 32'h0);
        check_eq("rstw_valid", {31'd0, pc_from_rom_ready}, 32'd0);

        // Branch while a read is outstanding at 0x8.
        data_base = 32'h50;
        rom_hold  = 1'b0;
        tick();
        tick();
        rom_hold = 1'b1;
        tick();
        check_eq("br_pending_addr", rom_addr, 32'h8);
        redirect_valid = 1'b1; redirect_sel = 1'b0; pc_add_imm_32 = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check_eq("drain_req", {31'd0, rom_req}, 32'd1);
        check_eq("drain_addr_hold", rom_addr, 32'h8);
        check_eq("drain_flush_valid", {31'd0, pc_from_rom_ready}, 32'd0);
        rom_hold = 1'b0;
        tick();
        check_eq("drain_discard_valid", {31'd0, pc_from_rom_ready}, 32'd0);
        check_eq("drain_new_addr", rom_addr, 32'h100);
        tick();
        rom_hold = 1'b1;
        tick();
        check_eq("br_sb_empty", 32'(sb_q.size()), 32'd0);

        // Misaligned JALR from IDLE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        redirect_valid = 1'b1; redirect_sel = 1'b1; rs1_data_add_imm_32_for_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check_eq("jalr_addr", rom_addr, 32'h200);
        rom_hold = 1'b0;
        tick();
        rom_hold = 1'b1;
        tick();
        check_eq("jalr_sb_empty", 32'(sb_q.size()), 32'd0);

        // Stall fills the skid and stops requests until decode drains it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        data_base = 32'hB6;
        rom_hold  = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        tick();
        check_eq("skid_no_req", {31'd0, rom_req}, 32'd0);
        check_eq("skid_hold_pc", pc, 32'h4);
        check_eq("skid_hold_valid", {31'd0, pc_from_rom_ready}, 32'd1);
        tick();
        check_eq("skid_still_no_req", {31'd0, rom_req}, 32'd0);
        stall    = 1'b0;
        rom_hold = 1'b1;
        tick();
        check_eq("skid_out_pc", pc, 32'h8);
        check_eq("skid_out_instr", instr, 32'hB8);
        check_eq("skid_resume_req", {31'd0, rom_req}, 32'd1);
        check_eq("skid_resume_addr", rom_addr, 32'hC);
        tick();
        check_eq("skid_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect during stall with data returning, target at the top of memory.
        rom_hold = 1'b0;
        tick();
        stall = 1'b1;
        redirect_valid = 1'b1; redirect_sel = 1'b0; pc_add_imm_32 = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check_eq("stall_redir_valid", {31'd0, pc_from_rom_ready}, 32'd0);
        check_eq("stall_redir_instr", instr, 32'h0000_0013);
        tick();
        tick();
        rom_hold = 1'b1;
        tick();
        check_eq("wrap_next_addr", rom_addr, 32'h4);
        check_eq("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
